datapath_sequencer: RTL

- Multi-cycle controller that sequences the register-file + ALU datapath (`datapath` module).
- Accepts one command at a time over a valid/ready interface and drives the datapath through the phases read/compute, capture, then write-back.
- Returns the result and zero flag over a valid/ready response interface.
- Sits between a test/host command source and `datapath`. It is the only agent driving the datapath's RegWrite, address, ALUFN and WriteData inputs.

---
 rtl/seq_pkg.sv | 30 +++
 rtl/datapath_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the datapath sequencer.
package seq_pkg;

    // Controller phases: accept, read/compute, write-back, respond.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        RESP = 2'd3
    } state_t;

    // cmd_op encodings.
    localparam logic OP_ALU   = 1'b0;
    localparam logic OP_LOADI = 1'b1;

    // Storage widths of the latched command; instances must keep
    // Abits <= CMD_ABITS_MAX and Dbits <= CMD_DBITS_MAX.
    localparam int CMD_ABITS_MAX = 16;
    localparam int CMD_DBITS_MAX = 64;

    typedef struct packed {
        logic                     op;
        logic [5:0]               alufn;
        logic [CMD_ABITS_MAX-1:0] rs;
        logic [CMD_ABITS_MAX-1:0] rt;
        logic [CMD_ABITS_MAX-1:0] rd;
        logic [CMD_DBITS_MAX-1:0] imm;
    } cmd_t;

endpackage

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller driving the register-file + ALU datapath:
// accept command, read/compute, write back, then return the result.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int Nloc  = 32,
    parameter int Dbits = 32,
    parameter int Abits = $clog2(Nloc),
    parameter int Cbits = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [5:0]       cmd_alufn,
    input  logic [Abits-1:0] cmd_rs,
    input  logic [Abits-1:0] cmd_rt,
    input  logic [Abits-1:0] cmd_rd,
    input  logic [Dbits-1:0] cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [Dbits-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [Cbits-1:0] ops_done,
    output logic             RegWrite,
    output logic [Abits-1:0] ReadAddr1,
    output logic [Abits-1:0] ReadAddr2,
    output logic [Abits-1:0] WriteAddr,
    output logic [5:0]       ALUFN,
    output logic [Dbits-1:0] WriteData,
    input  logic [Dbits-1:0] ALUResult,
    input  logic             FlagZ
);

    state_t           state_q, state_d;
    cmd_t             cmd_q;
    logic [Dbits-1:0] capture_q;
    logic             zcap_q;
    logic [Cbits-1:0] ops_q;
    logic             cmd_fire;
    logic             rsp_fire;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;
    assign ops_done = ops_q;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Latch the command on acceptance; later changes on the bus are ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q <= '0;
        end else if (cmd_fire) begin
            cmd_q <= '{op:    cmd_op,
                       alufn: cmd_alufn,
                       rs:    CMD_ABITS_MAX'(cmd_rs),
                       rt:    CMD_ABITS_MAX'(cmd_rt),
                       rd:    CMD_ABITS_MAX'(cmd_rd),
                       imm:   CMD_DBITS_MAX'(cmd_imm)};
        end
    end

    // Capture the value to write back at the end of EXEC.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            capture_q <= '0;
            zcap_q    <= 1'b0;
        end else if (state_q == EXEC) begin
            if (cmd_q.op == OP_LOADI) begin
                capture_q <= Dbits'(cmd_q.imm);
                zcap_q    <= (cmd_q.imm == '0);
            end else begin
                capture_q <= ALUResult;
                zcap_q    <= FlagZ;
            end
        end
    end

    // Completed-response counter, wraps silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      ops_q <= '0;
        else if (rsp_fire) ops_q <= ops_q + Cbits'(1);
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_result = '0;
        rsp_zero   = 1'b0;
        RegWrite   = 1'b0;
        ReadAddr1  = '0;
        ReadAddr2  = '0;
        WriteAddr  = '0;
        ALUFN      = '0;
        WriteData  = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = EXEC;
            end
            EXEC: begin
                ReadAddr1 = Abits'(cmd_q.rs);
                ReadAddr2 = Abits'(cmd_q.rt);
                ALUFN     = cmd_q.alufn;
                state_d   = WB;
            end
            WB: begin
                RegWrite  = 1'b1;
                ReadAddr1 = Abits'(cmd_q.rs);
                ReadAddr2 = Abits'(cmd_q.rt);
                ALUFN     = cmd_q.alufn;
                WriteAddr = Abits'(cmd_q.rd);
                WriteData = capture_q;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_result = capture_q;
                rsp_zero   = zcap_q;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
